// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/shift ops plus an iterative radix-2
// multiplier feeding the HI/LO accumulator, behind a valid/ready handshake.
module alu_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b1100;
    localparam logic [3:0] OP_XOR   = 4'b1101;
    localparam logic [3:0] OP_SLL   = 4'b1110;
    localparam logic [3:0] OP_SRL   = 4'b1111;
    localparam logic [3:0] OP_MADD  = 4'b1000;
    localparam logic [3:0] OP_MADDU = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               ready_q, ready_d;

    logic [3:0]         op_in;
    logic               unused_ctrl;
    logic [WIDTH-1:0]   sum_w, diff_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               in_is_mul, in_is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     step_sum;
    logic [PROD_W-1:0]  step_prod, prod_signed, acc_sum;

    assign op_in       = alu_ctrl[3:0];
    assign unused_ctrl = ^alu_ctrl[5:4];

    assign sum_w  = op_a + op_b;
    assign diff_w = op_a - op_b;

    // Single-cycle datapath
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_in)
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_ADD: begin
                alu_res = sum_w;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_NOT: alu_res = ~op_a;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SLL: alu_res = op_b << shamt;
            OP_SRL: alu_res = op_b >> shamt;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    assign in_is_mul    = (op_in == OP_MADD) || (op_in == OP_MADDU) || (op_in == OP_MUL);
    assign in_is_signed = (op_in == OP_MADD) || (op_in == OP_MUL);

    // Magnitudes are unsigned WIDTH-bit, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1)
    assign mag_a = (in_is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b = (in_is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

    // Right-shifting shift-add: multiplier sits in the low half of prod_q and is consumed LSB first
    assign step_sum    = {1'b0, prod_q[PROD_W-1:WIDTH]}
                       + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign step_prod   = {step_sum, prod_q[WIDTH-1:1]};
    assign prod_signed = neg_q ? (~prod_q + PROD_W'(1)) : prod_q;
    assign acc_sum     = {hi_q, lo_q} + prod_signed;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_is_mul) begin
                        op_d    = op_in;
                        neg_d   = in_is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        mcand_d = mag_a;
                        prod_d  = {{WIDTH{1'b0}}, mag_b};
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = step_prod;
                    if (cnt_q == '0) begin
                        state_d = S_ACC;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_ACC: begin
                state_d = S_IDLE;
                if (!flush) begin
                    out_valid_d = 1'b1;
                    ovf_d       = 1'b0;
                    if (op_q == OP_MUL) begin
                        result_d = prod_signed[WIDTH-1:0];
                        zero_d   = (prod_signed[WIDTH-1:0] == '0);
                    end else begin
                        hi_d     = acc_sum[PROD_W-1:WIDTH];
                        lo_d     = acc_sum[WIDTH-1:0];
                        result_d = acc_sum[WIDTH-1:0];
                        zero_d   = (acc_sum[WIDTH-1:0] == '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            mcand_q     <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ready_q     <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results are predicted at accept and
// popped when out_valid fires; covers latency, handshake, flush and reset.
module tb_alu_exec;

    localparam int unsigned W = 32;
    localparam int unsigned MUL_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [5:0]   alu_ctrl = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [4:0]   shamt = '0;
    logic         in_ready;
    logic         out_valid;
    logic         zero;
    logic         ovf;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .shamt(shamt), .flush(flush),
        .result(result), .out_valid(out_valid), .zero(zero), .ovf(ovf),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        v;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model; MADD/MADDU advance the model accumulator
    task automatic predict(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output exp_t e);
        logic [31:0] r;
        logic        v;
        logic [63:0] p;
        logic [63:0] acc;
        logic signed [63:0] sa;
        logic signed [63:0] sb_;
        r = '0; v = 1'b0; e.lat = 0;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h6: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'hC: r = ~a;
            4'hD: r = a ^ b;
            4'hE: r = b << sh;
            4'hF: r = b >> sh;
            4'h8, 4'h9: begin
                if (c == 4'h8) p = sa * sb_;
                else           p = {32'h0, a} * {32'h0, b};
                acc = {m_hi, m_lo} + p;
                m_hi = acc[63:32];
                m_lo = acc[31:0];
                r = m_lo;
                e.lat = MUL_LAT;
            end
            4'hA: begin
                p = sa * sb_;
                r = p[31:0];
                e.lat = MUL_LAT;
            end
            default: r = '0;
        endcase
        e.res = r; e.z = (r == 32'h0); e.v = v;
        e.hi = m_hi; e.lo = m_lo; e.acc_cyc = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", zero, e.z);
                check("ovf", ovf, e.v);
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    // Drive one request, holding in_valid until accepted
    task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        alu_ctrl = c; op_a = a; op_b = b; shamt = sh; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            if (push) predict(c[3:0], a, b, sh, e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) check("idle_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] codes [13];
        codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h9, 4'hA, 4'h3, 4'h7};

        repeat (3) @(negedge clk);
        check("rst_result", result, 64'h0);
        check("rst_out_valid", out_valid, 64'h0);
        check("rst_zero", zero, 64'h1);
        check("rst_ovf", ovf, 64'h0);
        check("rst_hi", hi, 64'h0);
        check("rst_lo", lo, 64'h0);
        check("rst_in_ready", in_ready, 64'h1);
        rst_n = 1'b1;

        // Single-cycle directed ops, issued back to back
        issue(6'h02, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b1);
        issue(6'h06, 32'd5, 32'd5, 5'd0, 1'b1);
        issue(6'h0E, 32'h0, 32'h1, 5'd31, 1'b1);
        issue(6'h0F, 32'h0, 32'h8000_0000, 5'd31, 1'b1);
        issue(6'h06, 32'h8000_0000, 32'h1, 5'd0, 1'b1);
        issue(6'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b1);
        issue(6'h01, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b1);
        issue(6'h0C, 32'h1234_5678, 32'h0, 5'd0, 1'b1);
        issue(6'h0D, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 1'b1);
        issue(6'h33, 32'h1111_1111, 32'h2222_2222, 5'd0, 1'b1);
        issue(6'h32, 32'h0000_0003, 32'h0000_0004, 5'd0, 1'b1);
        wait_idle();

        // MADD -3 * 7 from zero accumulator; in_ready low for the whole busy window
        issue(6'h08, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
        for (int k = 0; k < int'(W) + 1; k++) begin
            @(negedge clk);
            check("busy_in_ready", in_ready, 64'h0);
            check("busy_out_valid", out_valid, 64'h0);
        end
        @(negedge clk);
        check("ready_after_mul", in_ready, 64'h1);
        wait_idle();

        // Async reset at iteration 10 of a MADD
        issue(6'h08, 32'h0000_1234, 32'h0000_5678, 5'd0, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hi", hi, 64'h0);
        check("mid_rst_lo", lo, 64'h0);
        check("mid_rst_result", result, 64'h0);
        check("mid_rst_zero", zero, 64'h1);
        check("mid_rst_in_ready", in_ready, 64'h1);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // MADDU twice, then MUL with hi/lo untouched
        issue(6'h09, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1);
        issue(6'h09, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1);
        issue(6'h0A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
        wait_idle();
        check("maddu_hi", hi, 64'hFFFF_FFFC);
        check("maddu_lo", lo, 64'h0000_0002);

        // Flush at iteration 10: no completion, accumulator kept, next op accepted
        issue(6'h08, 32'd5, 32'd6, 5'd0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_hi", hi, {32'h0, m_hi});
        check("flush_lo", lo, {32'h0, m_lo});
        check("flush_in_ready", in_ready, 64'h1);
        issue(6'h02, 32'd100, 32'd23, 5'd0, 1'b1);
        wait_idle();

        // ADD held during a MUL busy window
        issue(6'h0A, 32'hFFFF_FFF9, 32'd9, 5'd0, 1'b1);
        issue(6'h02, 32'h7000_0000, 32'h7000_0000, 5'd0, 1'b1);
        wait_idle();

        // Flush in IDLE does not block a same-cycle request
        flush = 1'b1;
        issue(6'h06, 32'd9, 32'd10, 5'd0, 1'b1);
        flush = 1'b0;
        wait_idle();

        // Random mix
        for (int i = 0; i < 30; i++) begin
            logic [3:0] c;
            c = codes[$urandom_range(0, 12)];
            issue({2'($urandom_range(0, 3)), c}, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
        end
        wait_idle();
        check("sb_empty", sb.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
